// File: rtl/mac_seq.sv
// Multiply-accumulate sequencer: feeds operand pairs one at a time to an
// external shift-add multiplier, sums the products, then biases, shifts and saturates.
module mac_seq #(
  parameter int ACC_W = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [7:0]  cfg_len,
  input  logic [31:0] cfg_bias,
  input  logic [4:0]  cfg_shift,
  output logic        busy,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        op_valid,
  output logic        op_ready,
  output logic [15:0] mul_in1,
  output logic [15:0] mul_in2,
  output logic        mul_start,
  input  logic [31:0] mul_out,
  input  logic        mul_done,
  output logic [31:0] res_data,
  output logic        res_sat,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its data are held steady until that edge.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_MSTART = 3'd2,
    S_MWAIT  = 3'd3,
    S_POST   = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_q;
  logic [7:0]         cnt_q;
  logic [7:0]         cnt_inc;
  logic [31:0]        bias_q;
  logic [4:0]         shift_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W:0]     biased;
  logic [ACC_W:0]     shifted;
  logic               over;

  assign cnt_inc  = cnt_q + 8'd1;
  // One spare bit above the accumulator so the bias add can never wrap.
  assign biased   = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, bias_q};
  assign shifted  = biased >> shift_q;
  assign over     = |shifted[ACC_W:32];

  assign busy      = (state_q != S_IDLE);
  assign op_ready  = (state_q == S_FETCH);
  assign mul_start = (state_q == S_MSTART);
  assign res_valid = (state_q == S_OUT);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_start) state_d = (cfg_len == 8'd0) ? S_POST : S_FETCH;
      S_FETCH:  if (op_valid) state_d = S_MSTART;
      S_MSTART: state_d = S_MWAIT;
      S_MWAIT:  if (mul_done) state_d = (cnt_inc == len_q) ? S_POST : S_FETCH;
      S_POST:   state_d = S_OUT;
      S_OUT:    if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      bias_q   <= 32'd0;
      shift_q  <= 5'd0;
      acc_q    <= '0;
      mul_in1  <= 16'd0;
      mul_in2  <= 16'd0;
      res_data <= 32'd0;
      res_sat  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            len_q   <= cfg_len;
            bias_q  <= cfg_bias;
            shift_q <= cfg_shift;
            acc_q   <= '0;
            cnt_q   <= 8'd0;
          end
        end
        S_FETCH: begin
          if (op_valid) begin
            mul_in1 <= op_a;
            mul_in2 <= op_b;
          end
        end
        // mul_out is only meaningful in the done cycle, so it is summed right here.
        S_MWAIT: begin
          if (mul_done) begin
            acc_q <= acc_q + {{(ACC_W - 32){1'b0}}, mul_out};
            cnt_q <= cnt_inc;
          end
        end
        S_POST: begin
          res_sat  <= over;
          res_data <= over ? 32'hFFFF_FFFF : shifted[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a 19-cycle multiplier model, a result
// scoreboard fed by the driver and a monitor that pops on each result handshake.
module tb_mac_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic [31:0] cfg_bias = '0;
  logic [4:0]  cfg_shift = '0;
  logic        busy;
  logic [15:0] op_a = '0, op_b = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] mul_in1, mul_in2;
  logic        mul_start;
  logic [31:0] mul_out;
  logic        mul_done;
  logic [31:0] res_data;
  logic        res_sat;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  logic [32:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mac_seq #(.ACC_W(40)) dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .busy(busy),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
    .mul_out(mul_out), .mul_done(mul_done),
    .res_data(res_data), .res_sat(res_sat), .res_valid(res_valid), .res_ready(res_ready),
    .state_dbg(state_dbg)
  );

  // multiplier model: done is high in the 19th cycle after the start cycle
  logic        m_active = 1'b0;
  logic [4:0]  m_cnt = '0;
  logic        m_done = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [31:0] m_prod;
  logic        inj_done = 1'b0;
  logic [31:0] inj_out = 32'h0000_1000;

  assign m_prod   = m_a * m_b;
  assign mul_done = m_done | inj_done;
  assign mul_out  = m_done ? m_prod : (inj_done ? inj_out : 32'd0);

  always @(posedge clk) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_cnt    <= '0;
      m_done   <= 1'b0;
    end else if (m_active) begin
      m_cnt <= m_cnt + 5'd1;
      if (m_cnt == 5'd18) m_done <= 1'b1;
      if (m_cnt == 5'd19) begin
        m_done   <= 1'b0;
        m_active <= 1'b0;
      end
    end else if (mul_start) begin
      m_active <= 1'b1;
      m_cnt    <= 5'd1;
      m_a      <= mul_in1;
      m_b      <= mul_in2;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  logic        hold_v = 1'b0;
  logic [32:0] hold_d = '0;
  logic        prev_start = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      hold_v     = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (res_valid && hold_v) check("res_hold", {31'd0, res_sat, res_data}, {31'd0, hold_d});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL result_unexpected: got %0h expected none", {res_sat, res_data});
        end else begin
          check("result", {31'd0, res_sat, res_data}, {31'd0, exp_q.pop_front()});
        end
      end
      hold_v = res_valid && !res_ready;
      hold_d = {res_sat, res_data};
      if (mul_start) begin
        start_cnt++;
        check("start_pulse_width", {63'd0, prev_start}, 64'd0);
      end
      prev_start = mul_start;
      if (op_ready) check("op_ready_phase", {61'd0, m_active, res_valid, mul_start}, 64'd0);
      if (m_active) check("mul_in_stable", {32'd0, mul_in1, mul_in2}, {32'd0, m_a, m_b});
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] len, input logic [31:0] bias, input logic [4:0] sh);
    cfg_len   = len;
    cfg_bias  = bias;
    cfg_shift = sh;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic feed(input logic [15:0] a, input logic [15:0] b, input int gap, input bit inj);
    int k;
    op_valid = 1'b0;
    repeat (gap) tick();
    if (inj) begin
      k = 0;
      while (!op_ready && k < 100) begin
        tick();
        k++;
      end
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
    end
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (op_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      k++;
    end
    if (k >= 200) check("op_accept_timeout", 64'd0, 64'd1);
    op_valid = 1'b0;
  endtask

  task automatic finish(input int stall, input bit inj);
    int k;
    k = 0;
    while (!res_valid && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check("res_valid_timeout", 64'd0, 64'd1);
    for (int i = 0; i < stall; i++) begin
      if (inj && i == 1) inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", {61'd0, state_dbg}, 64'd0);
    check("rst_res_data", {32'd0, res_data}, 64'd0);
    reset = 1'b1;
    tick();

    // 6 + 20 + 42 + 10 = 78
    exp_q.push_back({1'b0, 32'd78});
    start_cnt = 0;
    start_job(8'd3, 32'd10, 5'd0);
    feed(16'd2, 16'd3, 0, 0);
    feed(16'd4, 16'd5, 0, 0);
    feed(16'd6, 16'd7, 0, 0);
    finish(0, 0);
    check("starts_job1", start_cnt, 3);

    // len=0: 0x100 >> 4
    exp_q.push_back({1'b0, 32'h10});
    start_cnt = 0;
    start_job(8'd0, 32'h100, 5'd4);
    lat = 1;
    @(negedge clk);
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("len0_latency", lat, 2);
    finish(0, 0);
    check("starts_len0", start_cnt, 0);

    // 2 * 0xFFFE0001 = 0x1_FFFC_0002 saturates, >>1 fits
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    start_job(8'd2, 32'd0, 5'd0);
    feed(16'hFFFF, 16'hFFFF, 0, 0);
    feed(16'hFFFF, 16'hFFFF, 0, 0);
    finish(0, 0);
    exp_q.push_back({1'b0, 32'hFFFE_0001});
    start_job(8'd2, 32'd0, 5'd1);
    feed(16'hFFFF, 16'hFFFF, 0, 0);
    feed(16'hFFFF, 16'hFFFF, 0, 0);
    finish(0, 0);

    // 20000 + 120000 + 3000 + 74560 = 217560, +64 = 217624, >>2 = 54406
    exp_q.push_back({1'b0, 32'd54406});
    start_cnt = 0;
    start_job(8'd4, 32'd64, 5'd2);
    feed(16'd100, 16'd200, 2, 0);
    cfg_len   = 8'd0;
    cfg_bias  = 32'hFFFF;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("busy_during_extra_start", {63'd0, busy}, 64'd1);
    feed(16'd300, 16'd400, 0, 0);
    feed(16'd1000, 16'd3, 3, 1);
    feed(16'h1234, 16'h0010, 1, 0);
    finish(5, 1);
    check("starts_job4", start_cnt, 4);
    repeat (3) tick();
    check("idle_after_job4", {62'd0, res_valid, busy}, 64'd0);

    // reset during MWAIT of pair 2 of 3
    start_job(8'd3, 32'd0, 5'd0);
    feed(16'd3, 16'd4, 0, 0);
    feed(16'd5, 16'd6, 0, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_flags", {59'd0, busy, op_ready, mul_start, res_valid, res_sat}, 64'd0);
    check("rst_mid_res_data", {32'd0, res_data}, 64'd0);
    check("rst_mid_mul_in", {32'd0, mul_in1, mul_in2}, 64'd0);
    check("rst_mid_state", {61'd0, state_dbg}, 64'd0);
    tick();

    exp_q.push_back({1'b0, 32'd64});
    start_cnt = 0;
    start_job(8'd1, 32'd1, 5'd0);
    feed(16'd7, 16'd9, 0, 0);
    finish(0, 0);
    check("starts_post_reset", start_cnt, 1);

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
# mac_seq

- Sequencer and accumulator that sits directly upstream of the 16x16 shift-add multiplier `mul_`.
- Accepts a job configuration and a stream of operand pairs, then issues them one at a time to the multiplier with a start pulse.
- Collects each 32-bit product on the multiplier's `done` and accumulates the products into a 40-bit sum.
- At the end of the job, adds a bias, right-shifts and saturates the sum, and presents one 32-bit result per job under a valid/ready handshake.

## Interface
- ACC_W, 40: accumulator width. Must be ≥ 32 + 8 so that 255 full-scale products cannot overflow.
- clk  in  1: single clock; all state updates on its rising edge.
- reset  in  1: synchronous, active-low; sampled on the rising edge of `clk`.
- cfg_start  in  1: job start; accepted only while `busy`=0.
- cfg_len  in  8: number of operand pairs in the job (0..255).
- cfg_bias  in  32: unsigned bias added after accumulation.
- cfg_shift  in  5: right-shift amount applied after the bias add.
- busy  out  1: high from the cycle after `cfg_start` is accepted until the result handshake completes.
- op_a, op_b  in  16 each: unsigned operand pair.
- op_valid  in  1 / op_ready  out  1: operand handshake.
- mul_in1, mul_in2  out  16 each: drive the multiplier's `in1`/`in2`.
- mul_start  out  1: drives the multiplier's `start`.
- mul_out  in  32 / mul_done  in  1: multiplier product and done pulse.
- res_data  out  32: job result.
- res_sat  out  1: the result was saturated.
- res_valid  in/out: `res_valid` is an output (1), `res_ready` is an input (1); together they form the result handshake.

## Operation
- States: IDLE, FETCH, MSTART, MWAIT, POST, OUT.
- IDLE
  - On `cfg_start`: latch len, bias and shift; clear the accumulator and the pair counter.
  - Go to POST if len=0, otherwise go to FETCH.
- FETCH
  - `op_ready`=1.
  - On `op_valid`: register `op_a`/`op_b` into `mul_in1`/`mul_in2`, then go to MSTART.
- MSTART
  - `mul_start`=1 for exactly this one cycle, then go to MWAIT.
- MWAIT
  - `mul_in1`/`mul_in2` stay stable in this state. The multiplier loads its operands one cycle after it leaves its IDLE, so they must not change.
  - On `mul_done`:
    - acc ← acc + zero-extend(`mul_out`); count ← count+1.
    - If the new count equals len, go to POST; otherwise go to FETCH.
  - `mul_out` is valid only in the `mul_done` cycle, so it is captured in that cycle.
- POST
  - One cycle.
  - t = (acc + bias) >> shift, computed at 41 bits.
  - If t > 0xFFFFFFFF: `res_data`=0xFFFFFFFF and `res_sat`=1. Otherwise `res_data`=t[31:0] and `res_sat`=0.
  - Then go to OUT.
- OUT
  - `res_valid`=1, with `res_data` and `res_sat` held constant.
  - On `res_ready`, go to IDLE.
- Arithmetic is unsigned throughout; there is no wrap-around anywhere.
- `mul_done` is ignored outside MWAIT.
- `cfg_start` is ignored outside IDLE.
- `op_valid` is ignored outside FETCH.
- Integration: the multiplier's active-high reset is driven by the inverse of `reset`, so that both blocks reset together.

## Timing
- Reset (`reset`=0 at an edge) forces the following on the next cycle, from any state including mid-job:
  - state IDLE;
  - `busy`, `op_ready`, `mul_start`, `res_valid` and `res_sat` all 0;
  - `res_data`, `mul_in1` and `mul_in2` all 0;
  - accumulator and counter cleared.
- `busy` rises on the edge that accepts `cfg_start`.
- Per pair: 1 FETCH cycle (when `op_valid` is already high), 1 MSTART cycle, then the MWAIT wait for `mul_done`.
  - With the team's multiplier, `mul_done` is high in the 19th cycle after `mul_start`, giving 21 cycles per pair.
  - No multiplier latency is hard-coded. Any latency ≥ 2 works.
- `mul_start` is a single-cycle pulse. It is never held, because a held start would retrigger the multiplier from its DONE→IDLE return.
- Jobs are not pipelined.
  - The last `mul_done` is followed by POST (1 cycle), then OUT.
  - The earliest the next `cfg_start` can be accepted is the cycle after the `res_ready` handshake.
- len=0: the IDLE→POST→OUT path gives `res_valid` 2 cycles after acceptance.
- Once `res_valid` rises, it stays high until `res_ready`, with data stable throughout.

## Test plan
- len=3; pairs (2,3), (4,5), (6,7); bias=10; shift=0; multiplier model with 19-cycle latency.
  - Required: `res_data`=78, `res_sat`=0.
  - Required: exactly three 1-cycle `mul_start` pulses.
- len=0, bias=0x100, shift=4.
  - Required: `res_data`=0x10, `res_valid` 2 cycles after `cfg_start`, no `mul_start`.
- len=2, pairs (0xFFFF,0xFFFF) twice, bias=0.
  - shift=0: required `res_data`=0xFFFFFFFF, `res_sat`=1.
  - Repeat with shift=1: required `res_data`=0xFFFE0001, `res_sat`=0.
- len=4, random gaps on `op_valid`, `res_ready` held low for 5 cycles, `cfg_start` pulsed while `busy`.
  - Required: `op_ready` high only in FETCH.
  - Required: operands stable through MWAIT.
  - Required: result correct and held stable while stalled.
  - Required: the extra `cfg_start` is ignored.
- Reset asserted during MWAIT of pair 2 of 3.
  - Required: all outputs 0 the next cycle.
  - Required: a following job (len=1, (7,9), bias=1) returns 64.
- `mul_done` pulsed while in FETCH and in OUT.
  - Required: no change to the accumulator, the counter or `res_data`.
